// File: rtl/test_fsl_loop.sv
// test_fsl_loop: FSL loopback endpoint.
// Receives one packet of 32-bit words from the FSL slave FIFO into a local
// buffer. It then echoes the packet unchanged on the FSL master FIFO.
// Optional feature, enabled by defining TEST_FSL_CSUM_EN: after the echo,
// one checksum word (the sum of the words, mod 2^32) is written with
// FSL_M_Control=1.
module test_fsl_loop #(
  parameter int PKT_WORDS = 8,
  parameter int CNT_W     = 3
) (
  input  logic        FSL_Clk,
  input  logic        FSL_Rst,
  output logic        FSL_S_Clk,
  output logic        FSL_S_Read,
  input  logic [0:31] FSL_S_Data,
  input  logic        FSL_S_Control,
  input  logic        FSL_S_Exists,
  output logic        FSL_M_Clk,
  output logic        FSL_M_Write,
  output logic [0:31] FSL_M_Data,
  output logic        FSL_M_Control,
  input  logic        FSL_M_Full
);

  localparam logic [1:0] ST_RECV = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
`ifdef TEST_FSL_CSUM_EN
  localparam logic [1:0] ST_CSUM = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] last_q, last_d;   // index of the final word (len - 1)
  logic [31:0]      mem_q [PKT_WORDS];
  logic [31:0]      s_word;
  logic             rd_fire, wr_fire, pkt_end;
`ifdef TEST_FSL_CSUM_EN
  logic [31:0]      sum_q, sum_d;
`endif

  assign FSL_S_Clk = FSL_Clk;
  assign FSL_M_Clk = FSL_Clk;

  // Bit 0 of the FSL bus is the MSB, so a plain value copy keeps the numeric meaning.
  assign s_word  = FSL_S_Data;
  assign rd_fire = (state_q == ST_RECV) && FSL_S_Exists;
  assign wr_fire = (state_q != ST_RECV) && !FSL_M_Full;
  // Check the packet end before the increment, so wr_ptr never wraps inside a packet.
  assign pkt_end = rd_fire && (FSL_S_Control || (wr_ptr_q == CNT_W'(PKT_WORDS - 1)));

  // Next-state logic for the receive / echo / checksum sequence.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
`ifdef TEST_FSL_CSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      ST_RECV: begin
        if (rd_fire) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
`ifdef TEST_FSL_CSUM_EN
          sum_d    = sum_q + s_word;
`endif
          if (pkt_end) begin
            last_d   = wr_ptr_q;
            rd_ptr_d = '0;
            state_d  = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (wr_fire) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == last_q) begin
`ifdef TEST_FSL_CSUM_EN
            state_d  = ST_CSUM;
`else
            wr_ptr_d = '0;
            state_d  = ST_RECV;
`endif
          end
        end
      end
`ifdef TEST_FSL_CSUM_EN
      ST_CSUM: begin
        if (wr_fire) begin
          sum_d    = '0;
          wr_ptr_d = '0;
          state_d  = ST_RECV;
        end
      end
`endif
      default: state_d = ST_RECV;
    endcase
  end

  // Control registers; an asynchronous reset discards any packet in progress.
  always_ff @(posedge FSL_Clk or posedge FSL_Rst) begin
    if (FSL_Rst) begin
      state_q  <= ST_RECV;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
`ifdef TEST_FSL_CSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
`ifdef TEST_FSL_CSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  // Packet buffer written by each consumed slave word.
  // NOTE: the buffer has no reset; stale contents are never read because rd_ptr only covers words of the current packet.
  always_ff @(posedge FSL_Clk) begin
    if (rd_fire) mem_q[wr_ptr_q] <= s_word;
  end

  // FSL handshake and data outputs, forced to zero while reset is held.
  always_comb begin
    FSL_S_Read    = 1'b0;
    FSL_M_Write   = 1'b0;
    FSL_M_Data    = '0;
    FSL_M_Control = 1'b0;
    if (!FSL_Rst) begin
      case (state_q)
        ST_RECV: FSL_S_Read = FSL_S_Exists;
        ST_SEND: begin
          FSL_M_Write = !FSL_M_Full;
          FSL_M_Data  = mem_q[rd_ptr_q];
        end
`ifdef TEST_FSL_CSUM_EN
        ST_CSUM: begin
          FSL_M_Write   = !FSL_M_Full;
          FSL_M_Data    = sum_q;
          FSL_M_Control = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_test_fsl_loop.sv
// tb_test_fsl_loop: randomized scoreboard bench for test_fsl_loop.
// A packet-level reference model pushes the expected master words into a
// queue when stimulus is issued. A separate monitor pops that queue on
// every master write. Checksum words are expected only when
// TEST_FSL_CSUM_EN is defined.
module tb_test_fsl_loop;

  localparam int PKT_WORDS = 8;

  typedef struct {
    logic [31:0] data;
    logic        ctrl;
  } word_t;

  logic        clk, rst;
  logic        s_clk, m_clk;
  logic        s_read, s_ctrl, s_exists;
  logic [0:31] s_data;
  logic        m_write, m_ctrl, m_full;
  logic [0:31] m_data;

  word_t sq[$];     // words waiting in the emulated slave FIFO
  word_t exp_q[$];  // expected master writes

  int  checks = 0;
  int  failures = 0;
  int  consumed = 0;
  int  exists_mode = 0;  // 0: always when data, 1: every other cycle, 2: random
  bit  full_mode = 0;    // 1: random back-pressure on the master side
  bit  toggle = 0;

  test_fsl_loop #(.PKT_WORDS(PKT_WORDS), .CNT_W(3)) dut (
    .FSL_Clk(clk), .FSL_Rst(rst),
    .FSL_S_Clk(s_clk), .FSL_S_Read(s_read), .FSL_S_Data(s_data),
    .FSL_S_Control(s_ctrl), .FSL_S_Exists(s_exists),
    .FSL_M_Clk(m_clk), .FSL_M_Write(m_write), .FSL_M_Data(m_data),
    .FSL_M_Control(m_ctrl), .FSL_M_Full(m_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a packet ends on a control word or at PKT_WORDS words.
  // It is echoed verbatim, then followed by its sum when the checksum is enabled.
  task automatic push_packet(input logic [31:0] w[$], input bit ctrl_last);
    logic [31:0] sum;
    int          n;
    sum = 0;
    n   = 0;
    for (int i = 0; i < w.size(); i++) begin
      word_t sw;
      sw.data = w[i];
      sw.ctrl = ctrl_last && (i == w.size() - 1);
      sq.push_back(sw);
      exp_q.push_back('{data: w[i], ctrl: 1'b0});
      sum = sum + w[i];
      n++;
      if (sw.ctrl || n == PKT_WORDS) begin
`ifdef TEST_FSL_CSUM_EN
        exp_q.push_back('{data: sum, ctrl: 1'b1});
`endif
        sum = 0;
        n   = 0;
      end
    end
  endtask

  task automatic push_ramp(input int first, input int count, input bit ctrl_last);
    logic [31:0] w[$];
    for (int i = 0; i < count; i++) w.push_back(32'(first + i));
    push_packet(w, ctrl_last);
  endtask

  task automatic push_random(input int npkts);
    for (int p = 0; p < npkts; p++) begin
      logic [31:0] w[$];
      int len;
      len = $urandom_range(PKT_WORDS, 1);
      for (int i = 0; i < len; i++) w.push_back($urandom);
      push_packet(w, (len < PKT_WORDS) ? 1'b1 : 1'($urandom % 2));
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sq.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(n >= budget), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  // Slave FIFO emulation: present the head word, pop it on a handshake edge.
  initial begin
    bit fire;
    s_exists = 1'b0;
    s_data   = '0;
    s_ctrl   = 1'b0;
    forever begin
      bit gate;
      @(negedge clk);
      gate = (exists_mode == 0) ? 1'b1 : (exists_mode == 1) ? toggle : 1'($urandom % 2);
      toggle = !toggle;
      if (sq.size() > 0 && gate) begin
        s_exists = 1'b1;
        s_data   = sq[0].data;
        s_ctrl   = sq[0].ctrl;
      end else begin
        s_exists = 1'b0;
        s_data   = '0;
        s_ctrl   = 1'b0;
      end
      #4;
      if (s_read && !s_exists) check("read_without_exists", 32'(s_read), 32'd0);
      fire = s_read && s_exists;
      @(posedge clk);
      if (fire) begin
        void'(sq.pop_front());
        consumed++;
      end
    end
  end

  // Monitor: drive back-pressure, then compare every master write with the scoreboard.
  initial begin
    m_full = 1'b0;
    forever begin
      @(negedge clk);
      m_full = full_mode ? 1'($urandom % 2) : 1'b0;
      #4;
      if (m_write) begin
        if (m_full) check("write_while_full", 32'(m_write), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", m_data, 32'hDEAD_BEEF);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          check("m_data", m_data, e.data);
          check("m_ctrl", 32'(m_ctrl), 32'(e.ctrl));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("rst_s_read", 32'(s_read), 32'd0);
    check("rst_m_write", 32'(m_write), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_ctrl", 32'(m_ctrl), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #2;
    check("idle_m_write", 32'(m_write), 32'd0);

    // Two full-length packets 1..8 back to back, no control flag.
    push_ramp(1, 8, 1'b0);
    push_ramp(1, 8, 1'b0);
    wait_drain("drain_ramp", 400);

    // Short packet terminated by the control flag.
    push_ramp(5, 3, 1'b1);
    // Single-word packet.
    push_ramp(32'h1234_5678, 1, 1'b1);
    wait_drain("drain_short", 200);

    // Random master back-pressure.
    full_mode = 1'b1;
    push_ramp(1, 8, 1'b0);
    push_random(4);
    wait_drain("drain_full", 2000);
    full_mode = 1'b0;

    // Slave data available only every other cycle.
    exists_mode = 1;
    push_ramp(1, 8, 1'b0);
    wait_drain("drain_toggle", 400);
    exists_mode = 0;

    // Checksum wrap-around.
    begin
      logic [31:0] w[$];
      w.push_back(32'hFFFF_FFFF);
      w.push_back(32'h0000_0002);
      push_packet(w, 1'b1);
    end
    wait_drain("drain_wrap", 200);

    // Reset after 4 words of a packet: the partial packet is never echoed.
    base = consumed;
    for (int i = 1; i <= 4; i++) sq.push_back('{data: 32'(100 + i), ctrl: 1'b0});
    n = 0;
    while (consumed < base + 4 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("partial_consumed_timeout", 32'(n >= 200), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_m_write", 32'(m_write), 32'd0);
    check("midrst_m_data", m_data, 32'd0);
    check("midrst_s_read", 32'(s_read), 32'd0);
    push_ramp(1, 8, 1'b0);
    @(negedge clk);
    #2;
    check("midrst_exists_shown", 32'(s_exists), 32'd1);
    check("midrst_s_read_held", 32'(s_read), 32'd0);
    rst = 1'b0;
    wait_drain("drain_after_rst", 400);

    // Random mix of slave gaps and master back-pressure.
    exists_mode = 2;
    full_mode   = 1'b1;
    push_random(6);
    wait_drain("drain_mix", 4000);
    exists_mode = 0;
    full_mode   = 1'b0;

    repeat (20) @(posedge clk);
    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    check("final_slave_empty", 32'(sq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
